// File: rtl/sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sr_flag_arbiter
//  Description : Bank of clocked set/reset flag bits shared by several
//                requesters. A round-robin arbiter applies at most one set
//                or reset operation per clock cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module sr_flag_arbiter #(
    parameter int NREQ   = 4,   // number of requesters (2..8)
    parameter int NFLAGS = 8,   // number of flag bits
    parameter int IDXW   = 3    // flag index width, 2**IDXW >= NFLAGS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        op,
    input  logic [NREQ*IDXW-1:0]   idx,
    input  logic                   clr_all,
    output logic [NREQ-1:0]        gnt,
    output logic [IDXW-1:0]        gnt_id,
    output logic                   err,
    output logic [NFLAGS-1:0]      q
);

    localparam int c_ptrw = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NFLAGS-1:0] q_q,      q_d;
    logic [NREQ-1:0]   gnt_q,    gnt_d;
    logic [IDXW-1:0]   gnt_id_q, gnt_id_d;
    logic              err_q,    err_d;
    logic [c_ptrw-1:0] ptr_q,    ptr_d;

    logic [NREQ-1:0]   w_elig;
    logic              w_found;
    logic [c_ptrw-1:0] w_win;
    logic [IDXW-1:0]   w_idx_win;
    logic [c_ptrw-1:0] w_ptr_nxt;
    int                w_cand;
    int                w_nxt;

    // Round-robin search: first eligible requester starting at ptr. A
    // requester whose grant is currently visible is masked so a held
    // request cannot win twice in a row.
    always_comb begin
        w_elig  = req & ~gnt_q;
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = int'(ptr_q) + k;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            if (!w_found && w_elig[w_cand[c_ptrw-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[c_ptrw-1:0];
            end
        end
        w_idx_win = idx[w_win*IDXW +: IDXW];
        w_nxt     = int'(w_win) + 1;
        if (w_nxt >= NREQ) begin
            w_nxt = 0;
        end
        w_ptr_nxt = w_nxt[c_ptrw-1:0];
    end

    // Next-state: clear-all has priority over a grant; an out-of-range
    // index still consumes the grant but only raises err.
    always_comb begin
        q_d      = q_q;
        gnt_d    = '0;
        gnt_id_d = gnt_id_q;
        err_d    = 1'b0;
        ptr_d    = ptr_q;
        if (clr_all) begin
            q_d = '0;
        end else if (w_found) begin
            gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
            gnt_id_d = w_idx_win;
            ptr_d    = w_ptr_nxt;
            err_d    = 1'b1;
            for (int f = 0; f < NFLAGS; f++) begin
                if (int'(w_idx_win) == f) begin
                    q_d[f] = op[w_win];
                    err_d  = 1'b0;
                end
            end
        end
    end

    // State register with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q      <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            err_q    <= 1'b0;
            ptr_q    <= '0;
        end else begin
            q_q      <= q_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            err_q    <= err_d;
            ptr_q    <= ptr_d;
        end
    end

    assign q      = q_q;
    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_flag_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_flag_arbiter
//  Description : Directed self-checking bench for sr_flag_arbiter, with a
//                second instance configured for NFLAGS=6.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sr_flag_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req,  op,  gnt;
    logic [11:0] idx;
    logic        clr_all;
    logic [2:0]  gnt_id;
    logic        err;
    logic [7:0]  q;

    logic [3:0]  req6, op6, gnt6;
    logic [11:0] idx6;
    logic [2:0]  gnt_id6;
    logic        err6;
    logic [5:0]  q6;

    int n_tests;
    int n_fail;

    sr_flag_arbiter #(.NREQ(4), .NFLAGS(8), .IDXW(3)) u_dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
        .clr_all(clr_all), .gnt(gnt), .gnt_id(gnt_id), .err(err), .q(q)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAGS(6), .IDXW(3)) u_dut6 (
        .clk(clk), .rst(rst), .req(req6), .op(op6), .idx(idx6),
        .clr_all(1'b0), .gnt(gnt6), .gnt_id(gnt_id6), .err(err6), .q(q6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [3:0] e_gnt,
                            input logic [7:0] e_q, input logic e_err);
        chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        chk({tag, ".q"},   32'(q),   32'(e_q));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; clr_all = 1'b0;
        req = '0; op = '0; idx = '0;
        req6 = '0; op6 = '0; idx6 = '0;

        // Reset, then idle
        step(); step();
        rst = 1'b0;
        chk("rst.gnt_id", 32'(gnt_id), 32'd0);
        chk_main("rst", 4'b0000, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_main("idle", 4'b0000, 8'h00, 1'b0);
        end

        // Single set then reset of flag 3 by requester 0
        req = 4'b0001; op = 4'b0001; idx = 12'(3);
        step();
        chk_main("set3", 4'b0001, 8'h08, 1'b0);
        chk("set3.gnt_id", 32'(gnt_id), 32'd3);
        req = '0;
        step();
        chk_main("set3.gap", 4'b0000, 8'h08, 1'b0);
        req = 4'b0001; op = 4'b0000; idx = 12'(3);
        step();
        chk_main("clr3", 4'b0001, 8'h00, 1'b0);
        req = '0;

        // All four set distinct flags after reset: grants 0,1,2,3
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111; op = 4'b1111; idx = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int k = 0; k < 4; k++) begin
            step();
            chk_main($sformatf("rr%0d", k), 4'(1 << k), 8'((1 << (k + 1)) - 1), 1'b0);
            req[k] = 1'b0;
        end

        // Conflict on flag 5 with ptr=0: req1 set, req2 reset -> q[5]=0
        req = 4'b0110; op = 4'b0010; idx = {3'd0, 3'd5, 3'd5, 3'd0};
        step();
        chk_main("cf0.a", 4'b0010, 8'h2F, 1'b0);
        req = 4'b0100;
        step();
        chk_main("cf0.b", 4'b0100, 8'h0F, 1'b0);
        req = '0;
        step();

        // Move ptr to 2 by granting requester 1 (sets flag 4)
        req = 4'b0010; op = 4'b0010; idx = {3'd0, 3'd0, 3'd4, 3'd0};
        step();
        chk_main("ptr2", 4'b0010, 8'h1F, 1'b0);
        req = '0;
        step();

        // Conflict on flag 5 with ptr=2: req2 first, req1 last -> q[5]=1
        req = 4'b0110; op = 4'b0010; idx = {3'd0, 3'd5, 3'd5, 3'd0};
        step();
        chk_main("cf2.a", 4'b0100, 8'h1F, 1'b0);
        req = 4'b0010;
        step();
        chk_main("cf2.b", 4'b0010, 8'h3F, 1'b0);
        req = '0;
        step();

        // NFLAGS=6 instance: out-of-range index raises err, q unchanged
        req6 = 4'b0001; op6 = 4'b0001; idx6 = 12'(7);
        step();
        chk("oor.gnt", 32'(gnt6), 32'b0001);
        chk("oor.err", 32'(err6), 32'd1);
        chk("oor.q",   32'(q6),   32'h00);
        chk("oor.id",  32'(gnt_id6), 32'd7);
        req6 = '0;
        step();
        chk("oor.err_pulse", 32'(err6), 32'd0);
        chk("oor.gnt_pulse", 32'(gnt6), 32'd0);
        req6 = 4'b0001; op6 = 4'b0001; idx6 = 12'(5);
        step();
        chk("top6.q",   32'(q6),   32'h20);
        chk("top6.err", 32'(err6), 32'd0);
        req6 = '0;

        // Fill q to FF (ptr=2 here: req3 wins before req0)
        req = 4'b1001; op = 4'b1001; idx = {3'd7, 3'd0, 3'd0, 3'd6};
        step();
        chk_main("fill.a", 4'b1000, 8'hBF, 1'b0);
        req = 4'b0001;
        step();
        chk_main("fill.b", 4'b0001, 8'hFF, 1'b0);

        // clr_all with a pending request, which is granted next cycle
        req = 4'b0010; op = 4'b0010; idx = {3'd0, 3'd0, 3'd2, 3'd0};
        clr_all = 1'b1;
        step();
        chk_main("clr", 4'b0000, 8'h00, 1'b0);
        chk("clr.gnt_id", 32'(gnt_id), 32'd6);
        clr_all = 1'b0;
        step();
        chk_main("clr.pend", 4'b0010, 8'h04, 1'b0);
        chk("clr.pend_id", 32'(gnt_id), 32'd2);

        // Reset with requests held: all clear, then restart from ptr=0
        req = 4'b1111; op = 4'b1111; idx = {3'd3, 3'd2, 3'd1, 3'd0};
        rst = 1'b1;
        step();
        chk_main("rst2", 4'b0000, 8'h00, 1'b0);
        chk("rst2.gnt_id", 32'(gnt_id), 32'd0);
        rst = 1'b0;
        step();
        chk_main("rst2.ptr0", 4'b0001, 8'h01, 1'b0);
        req = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
